// File: rtl/axis_led_pkg.sv
// axis_led_pkg: shared encodings for the AXI-Stream LED mode controller.
// Holds the LED mode encodings, the command byte field layout, the
// command FSM state encoding and a helper for the 2^r rate divider.
package axis_led_pkg;

   // LED pattern modes carried in command bits [1:0]
   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_CHASE = 2'b11
   } led_mode_e;

   // Command byte field layout
   localparam int CMD_MODE_LSB = 0;
   localparam int CMD_MODE_W   = 2;
   localparam int CMD_RATE_LSB = 2;
   localparam int CMD_RATE_W   = 2;
   localparam int CMD_MASK_LSB = 4;
   localparam int CMD_MASK_W   = 4;

   // Width of the tick counter that divides by 2^r (r <= 3 -> up to 8)
   localparam int RATE_CNT_W = 3;

   // Command FSM: RUN accepts beats, APPLY is the one-cycle load slot
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_APPLY = 1'b1
   } fsm_state_e;

   // Last count value of the rate divider for a given rate select r
   function automatic logic [RATE_CNT_W-1:0] rate_last(input logic [CMD_RATE_W-1:0] r);
      return RATE_CNT_W'((4'd1 << r) - 4'd1);
   endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler of PERIOD cycles followed by a 2^r tick divider.
// step is a one-cycle pulse every PERIOD*2^r cycles. clear restarts both
// counters from zero and suppresses any tick that lands on the same cycle.
module led_tick_gen
   import axis_led_pkg::*;
#(
   parameter int PERIOD = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [CMD_RATE_W-1:0] r,
   output logic                  step
);

   localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PERIOD - 1);

   logic [PW-1:0]         pre_q;
   logic [PW-1:0]         pre_d;
   logic [RATE_CNT_W-1:0] rate_q;
   logic [RATE_CNT_W-1:0] rate_d;
   logic                  tick;

   // Next-state for prescaler and rate divider; clear wins over counting
   always_comb begin
      tick   = (pre_q == PRE_LAST) && !clear;
      // >= keeps the divider from running away if r ever shrinks mid-count
      step   = tick && (rate_q >= rate_last(r));
      pre_d  = pre_q;
      rate_d = rate_q;
      if (clear) begin
         pre_d  = '0;
         rate_d = '0;
      end else begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         if (tick) begin
            rate_d = step ? '0 : rate_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q  <= '0;
         rate_q <= '0;
      end else begin
         pre_q  <= pre_d;
         rate_q <= rate_d;
      end
   end

endmodule

// File: rtl/axis_led_mode.sv
// axis_led_mode: AXI-Stream command sink driving an LED bank.
// Each accepted byte selects mode [1:0], rate r [3:2] and LED mask [7:4].
// A handshake moves the FSM to APPLY for one cycle, which loads the command
// and restarts the pattern; led is registered one cycle after that state.
// Optional macro AXIS_LED_PWM_EN gates every lit LED with a 16-slot PWM
// whose on-time is PWM_DUTY slots.
module axis_led_mode
   import axis_led_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 125_000_000,
   parameter int BLINK_HZ    = 2,
   parameter int NUM_LEDS    = 4,
   parameter int PWM_DUTY    = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   input  logic                s_axis_tlast,
   output logic [NUM_LEDS-1:0] led,
   output logic [1:0]          mode
);

   localparam int PERIOD = CLK_FREQ_HZ / (2 * BLINK_HZ);
   localparam int IW     = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_LEDS - 1);

   // Command FSM and pending command
   fsm_state_e            state_q;
   fsm_state_e            state_d;
   logic                  tready_q;
   logic                  tready_d;
   led_mode_e             cmd_mode_q;
   led_mode_e             cmd_mode_d;
   logic [CMD_RATE_W-1:0] cmd_rate_q;
   logic [CMD_RATE_W-1:0] cmd_rate_d;
   logic [NUM_LEDS-1:0]   cmd_mask_q;
   logic [NUM_LEDS-1:0]   cmd_mask_d;

   // Applied command and pattern state
   led_mode_e             mode_q;
   led_mode_e             mode_d;
   logic [CMD_RATE_W-1:0] rate_q;
   logic [CMD_RATE_W-1:0] rate_d;
   logic [NUM_LEDS-1:0]   mask_q;
   logic [NUM_LEDS-1:0]   mask_d;
   logic                  phase_q;
   logic                  phase_d;
   logic [IW-1:0]         idx_q;
   logic [IW-1:0]         idx_d;

   // Output register
   logic [NUM_LEDS-1:0]   led_q;
   logic [NUM_LEDS-1:0]   led_d;

   logic                  handshake;
   logic                  apply;
   logic                  step;
   logic                  pwm_on;
   logic [NUM_LEDS-1:0]   chase_sel;

   // tlast carries no meaning here and the mask bits above NUM_LEDS are dropped
   logic [8:0]            unused_inputs;
   assign unused_inputs = {s_axis_tlast, s_axis_tdata};

   assign handshake     = s_axis_tvalid && tready_q;
   assign apply         = (state_q == ST_APPLY);
   assign s_axis_tready = tready_q;
   assign led           = led_q;
   assign mode          = mode_q;

   // FSM next state: accept in RUN, spend exactly one cycle in APPLY
   always_comb begin
      state_d    = state_q;
      tready_d   = tready_q;
      cmd_mode_d = cmd_mode_q;
      cmd_rate_d = cmd_rate_q;
      cmd_mask_d = cmd_mask_q;
      case (state_q)
         ST_RUN: begin
            tready_d = 1'b1;
            if (handshake) begin
               state_d    = ST_APPLY;
               tready_d   = 1'b0;
               cmd_mode_d = led_mode_e'(s_axis_tdata[CMD_MODE_LSB +: CMD_MODE_W]);
               cmd_rate_d = s_axis_tdata[CMD_RATE_LSB +: CMD_RATE_W];
               cmd_mask_d = s_axis_tdata[CMD_MASK_LSB +: NUM_LEDS];
            end
         end
         ST_APPLY: begin
            state_d  = ST_RUN;
            tready_d = 1'b1;
         end
         default: begin
            state_d  = ST_RUN;
            tready_d = 1'b1;
         end
      endcase
   end

   // FSM state, registered tready and pending command; tready stays low in reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_RUN;
         tready_q   <= 1'b0;
         cmd_mode_q <= MODE_OFF;
         cmd_rate_q <= '0;
         cmd_mask_q <= '0;
      end else begin
         state_q    <= state_d;
         tready_q   <= tready_d;
         cmd_mode_q <= cmd_mode_d;
         cmd_rate_q <= cmd_rate_d;
         cmd_mask_q <= cmd_mask_d;
      end
   end

   // Blink/chase timing; APPLY restarts it so a repeated command restarts the pattern
   led_tick_gen #(
      .PERIOD (PERIOD)
   ) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (apply),
      .r     (rate_q),
      .step  (step)
   );

   // Load the pending command in APPLY and advance blink phase / chase index on step
   always_comb begin
      mode_d  = mode_q;
      rate_d  = rate_q;
      mask_d  = mask_q;
      phase_d = phase_q;
      idx_d   = idx_q;
      if (apply) begin
         mode_d  = cmd_mode_q;
         rate_d  = cmd_rate_q;
         mask_d  = cmd_mask_q;
         phase_d = 1'b1;
         idx_d   = '0;
      end else if (step) begin
         phase_d = !phase_q;
         idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Applied command and pattern registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q  <= MODE_OFF;
         rate_q  <= '0;
         mask_q  <= '0;
         phase_q <= 1'b0;
         idx_q   <= '0;
      end else begin
         mode_q  <= mode_d;
         rate_q  <= rate_d;
         mask_q  <= mask_d;
         phase_q <= phase_d;
         idx_q   <= idx_d;
      end
   end

   // One-hot chase position; with a single LED this is always bit 0
   generate
      for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chase
         assign chase_sel[gi] = (idx_q == IW'(gi));
      end
   endgenerate

`ifdef AXIS_LED_PWM_EN
   logic       pwm_step;
   logic [3:0] pwm_cnt_q;
   logic [3:0] pwm_cnt_d;

   // Single-cycle slot advance; never cleared so APPLY leaves PWM phase alone
   led_tick_gen #(
      .PERIOD (1)
   ) u_pwm_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (1'b0),
      .r     ('0),
      .step  (pwm_step)
   );

   // PWM slot counter next value
   always_comb begin
      pwm_cnt_d = pwm_step ? pwm_cnt_q + 4'd1 : pwm_cnt_q;
   end

   // Free-running 16-slot PWM counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
      end
   end

   assign pwm_on = ({1'b0, pwm_cnt_q} < 5'(PWM_DUTY));
`else
   assign pwm_on = 1'b1;
`endif

   // LED pattern from the applied state, optionally gated by PWM
   always_comb begin
      case (mode_q)
         MODE_OFF:   led_d = '0;
         MODE_ON:    led_d = mask_q;
         MODE_BLINK: led_d = phase_q ? mask_q : '0;
         MODE_CHASE: led_d = chase_sel & mask_q;
         default:    led_d = '0;
      endcase
      led_d = led_d & {NUM_LEDS{pwm_on}};
   end

   // Registered LED drive keeps the pins glitch-free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

endmodule

// File: tb/tb_axis_led_mode.sv
// tb_axis_led_mode: directed bench for axis_led_mode with P = 8 cycles.
// Expected LED values are queued when a command is sent and popped one per
// cycle as the DUT drives led. Build with AXIS_LED_PWM_EN for the PWM run.
module tb_axis_led_mode;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] s_axis_tdata;
   logic       s_axis_tvalid;
   logic       s_axis_tready;
   logic       s_axis_tlast;
   logic [3:0] led;
   logic [1:0] mode;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] led;
   } exp_t;

   exp_t sb[$];

   axis_led_mode #(
      .CLK_FREQ_HZ (16),
      .BLINK_HZ    (1),
      .NUM_LEDS    (4),
      .PWM_DUTY    (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .led           (led),
      .mode          (mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_led(input string tag, input logic [3:0] val, input int n);
      exp_t e;
      e.tag = tag;
      e.led = val;
      for (int i = 0; i < n; i++) sb.push_back(e);
   endtask

   // Advance n cycles, comparing led against the queue head each cycle
   task automatic step_check(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, {4'h0, led}, {4'h0, e.led});
         end
      end
   endtask

   task automatic skip(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Present one beat; returns #1 after the handshake edge (inside APPLY)
   task automatic send(input logic [7:0] d);
      int guard;
      guard = 0;
      s_axis_tdata  = d;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("tready_before_hs", {7'h0, s_axis_tready}, 8'h01);
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      chk("tready_in_apply", {7'h0, s_axis_tready}, 8'h00);
      $display("sent command %02h", d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tlast  = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("rst_tready", {7'h0, s_axis_tready}, 8'h00);
      chk("rst_led", {4'h0, led}, 8'h00);
      chk("rst_mode", {6'h0, mode}, 8'h00);
      rst = 1'b0;
      #1;
      chk("rel_tready_before_edge", {7'h0, s_axis_tready}, 8'h00);
      @(posedge clk); #1;
      chk("rel_tready_after_edge", {7'h0, s_axis_tready}, 8'h01);
      chk("rel_led", {4'h0, led}, 8'h00);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

`ifdef AXIS_LED_PWM_EN
      begin
         int hi;
         hi = 0;
         send(8'hF1);
         skip(2);
         for (int i = 0; i < 32; i++) begin
            @(posedge clk); #1;
            if (led === 4'hF) hi++;
            else chk("pwm_dark", {4'h0, led}, 8'h00);
         end
         chk("pwm_on_count", 8'(hi), 8'd8);
         $display("pwm: %0d of 32 cycles lit", hi);
      end
`else
      // ON, mask F: exact two-cycle latency
      send(8'hF1);
      push_led("on_n1_old", 4'h0, 1);
      push_led("on_lit", 4'hF, 4);
      step_check(5);
      chk("on_mode", {6'h0, mode}, 8'h01);

      // BLINK r=0, mask 5: 8-cycle phases, restarting lit
      send(8'h52);
      push_led("blink0_n1_old", 4'hF, 1);
      push_led("blink0_on1", 4'h5, 8);
      push_led("blink0_off", 4'h0, 8);
      push_led("blink0_on2", 4'h5, 8);
      step_check(25);
      chk("blink0_mode", {6'h0, mode}, 8'h02);

      // BLINK r=2: 32-cycle phases
      send(8'h5A);
      skip(1);
      push_led("blink2_on1", 4'h5, 32);
      push_led("blink2_off", 4'h0, 32);
      push_led("blink2_on2", 4'h5, 4);
      step_check(68);

      // CHASE r=0, mask F: 1,2,4,8,1
      send(8'hF3);
      skip(1);
      push_led("chaseF_1", 4'h1, 8);
      push_led("chaseF_2", 4'h2, 8);
      push_led("chaseF_4", 4'h4, 8);
      push_led("chaseF_8", 4'h8, 8);
      push_led("chaseF_wrap", 4'h1, 8);
      step_check(40);
      chk("chase_mode", {6'h0, mode}, 8'h03);

      // CHASE mask 6: 0,2,4,0
      send(8'h63);
      skip(1);
      push_led("chase6_0a", 4'h0, 8);
      push_led("chase6_2", 4'h2, 8);
      push_led("chase6_4", 4'h4, 8);
      push_led("chase6_0b", 4'h0, 8);
      step_check(32);

      // Held tvalid: 0x52 then 0xF1 accepted two cycles apart, tlast ignored
      chk("b2b_ready", {7'h0, s_axis_tready}, 8'h01);
      s_axis_tdata  = 8'h52;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = 1'b1;
      @(posedge clk); #1;
      chk("b2b_apply1_tready", {7'h0, s_axis_tready}, 8'h00);
      s_axis_tdata = 8'hF1;
      s_axis_tlast = 1'b0;
      @(posedge clk); #1;
      chk("b2b_run_tready", {7'h0, s_axis_tready}, 8'h01);
      chk("b2b_mode_blink", {6'h0, mode}, 8'h02);
      s_axis_tlast = 1'b1;
      @(posedge clk); #1;
      chk("b2b_apply2_tready", {7'h0, s_axis_tready}, 8'h00);
      chk("b2b_blink_restart_on", {4'h0, led}, 8'h05);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      @(posedge clk); #1;
      chk("b2b_mode_on", {6'h0, mode}, 8'h01);
      chk("b2b_led_still_blink", {4'h0, led}, 8'h05);
      push_led("b2b_final", 4'hF, 4);
      step_check(4);
      $display("back-to-back commands checked");

      // Asynchronous reset in the middle of a chase
      send(8'hF3);
      skip(1);
      push_led("pre_rst_chase1", 4'h1, 8);
      push_led("pre_rst_chase2", 4'h2, 3);
      step_check(11);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_led", {4'h0, led}, 8'h00);
      chk("async_rst_mode", {6'h0, mode}, 8'h00);
      chk("async_rst_tready", {7'h0, s_axis_tready}, 8'h00);
      skip(2);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst2_tready", {7'h0, s_axis_tready}, 8'h01);
      $display("async reset mid-chase checked");

      // Reset during APPLY drops the pending command
      send(8'hF1);
      rst = 1'b1;
      #1;
      chk("apply_rst_tready", {7'h0, s_axis_tready}, 8'h00);
      chk("apply_rst_led", {4'h0, led}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      push_led("dropped_cmd", 4'h0, 6);
      step_check(6);
      chk("dropped_mode", {6'h0, mode}, 8'h00);
      chk("dropped_tready", {7'h0, s_axis_tready}, 8'h01);
      $display("reset during APPLY checked");
`endif

      chk("scoreboard_empty", 8'(sb.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
